// File: rtl/pc_gen.sv
// Program-counter generator: holds the fetch PC and offers it over valid/ready, with
// sequential advance, redirect/trap, halt/resume, misaligned-target detection and a fetch count.
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter bit              C_EXT        = 1'b0,
  parameter int unsigned     CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [XLEN-1:0]  pc,
  output logic             pc_valid,
  input  logic             pc_ready,
  input  logic             stall,
  input  logic             is_compressed,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_target,
  input  logic             trap,
  input  logic [XLEN-1:0]  trap_vec,
  input  logic             halt_req,
  input  logic             resume,
  output logic             halted,
  output logic             misalign,
  output logic [XLEN-1:0]  misalign_addr,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {StBoot, StRun, StHalted} state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  mis_addr_q, mis_addr_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             fire;
  logic             target_misaligned;
  logic [XLEN-1:0]  trap_base;
  logic [XLEN-1:0]  inc;

  assign pc_valid = (state_q == StRun) & ~stall;
  assign fire     = pc_valid & pc_ready;

  // Low two bits of the trap vector are ignored; masking keeps every input bit referenced.
  assign trap_base = trap_vec & ~XLEN'(3);

  assign target_misaligned = C_EXT ? redirect_target[0] : (redirect_target[1:0] != 2'b00);
  assign inc               = (C_EXT && is_compressed) ? XLEN'(2) : XLEN'(4);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:   state_d = StRun;
      StRun:    if (halt_req) state_d = StHalted;
      StHalted: if (resume && !halt_req) state_d = StRun;
      default:  state_d = StBoot;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    mis_d      = 1'b0;
    mis_addr_d = mis_addr_q;
    cnt_d      = fire ? cnt_q + 1'b1 : cnt_q;
    if (trap) begin
      pc_d = trap_base;
    end else if (redirect && !target_misaligned) begin
      pc_d = redirect_target;
    end else if (redirect) begin
      // Misaligned target vectors to the trap handler and records the bad address.
      pc_d       = trap_base;
      mis_d      = 1'b1;
      mis_addr_d = redirect_target;
    end else if (fire) begin
      pc_d = pc_q + inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StBoot;
      pc_q       <= RESET_VECTOR;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc            = pc_q;
  assign halted        = (state_q == StHalted);
  assign misalign      = mis_q;
  assign misalign_addr = mis_addr_q;
  assign fetch_count   = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a C_EXT=0 instance with a 3-bit counter and a C_EXT=1 instance,
// both driven by the same stimulus; expectations are queued per step and checked after the edge.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst, pc_ready, stall, is_compressed, redirect, trap, halt_req, resume;
  logic [31:0] redirect_target, trap_vec;

  logic [31:0] a_pc, a_ma, b_pc, b_ma, b_cnt;
  logic [2:0]  a_cnt;
  logic        a_v, a_h, a_m, b_v, b_h, b_m;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    bit          dut_b;
    logic [31:0] pc;
    logic        v;
    logic        h;
    logic        m;
    logic [31:0] ma;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0000_1000), .C_EXT(1'b0), .CNT_W(3)) dut_a (
    .clk(clk), .rst(rst), .pc(a_pc), .pc_valid(a_v), .pc_ready(pc_ready), .stall(stall),
    .is_compressed(is_compressed), .redirect(redirect), .redirect_target(redirect_target),
    .trap(trap), .trap_vec(trap_vec), .halt_req(halt_req), .resume(resume), .halted(a_h),
    .misalign(a_m), .misalign_addr(a_ma), .fetch_count(a_cnt)
  );

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(1'b1), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .pc(b_pc), .pc_valid(b_v), .pc_ready(pc_ready), .stall(stall),
    .is_compressed(is_compressed), .redirect(redirect), .redirect_target(redirect_target),
    .trap(trap), .trap_vec(trap_vec), .halt_req(halt_req), .resume(resume), .halted(b_h),
    .misalign(b_m), .misalign_addr(b_ma), .fetch_count(b_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string field, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  task automatic push(input string tag, input bit dut_b, input logic [31:0] pc, input logic v,
                      input logic h, input logic m, input logic [31:0] ma,
                      input logic [31:0] cnt);
    exp_t e;
    e.tag = tag; e.dut_b = dut_b; e.pc = pc; e.v = v; e.h = h; e.m = m; e.ma = ma; e.cnt = cnt;
    sb.push_back(e);
  endtask

  // Advance one edge, then pop and compare every queued expectation.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.dut_b) begin
        chk(e.tag, "pc", b_pc, e.pc);
        chk(e.tag, "pc_valid", {31'b0, b_v}, {31'b0, e.v});
        chk(e.tag, "halted", {31'b0, b_h}, {31'b0, e.h});
        chk(e.tag, "misalign", {31'b0, b_m}, {31'b0, e.m});
        chk(e.tag, "misalign_addr", b_ma, e.ma);
        chk(e.tag, "fetch_count", b_cnt, e.cnt);
      end else begin
        chk(e.tag, "pc", a_pc, e.pc);
        chk(e.tag, "pc_valid", {31'b0, a_v}, {31'b0, e.v});
        chk(e.tag, "halted", {31'b0, a_h}, {31'b0, e.h});
        chk(e.tag, "misalign", {31'b0, a_m}, {31'b0, e.m});
        chk(e.tag, "misalign_addr", a_ma, e.ma);
        chk(e.tag, "fetch_count", {29'b0, a_cnt}, e.cnt);
      end
    end
  endtask

  initial begin
    rst = 1'b1; pc_ready = 1'b1; stall = 1'b0; is_compressed = 1'b0; redirect = 1'b0;
    trap = 1'b0; halt_req = 1'b0; resume = 1'b0; redirect_target = '0; trap_vec = '0;

    // Reset and boot
    tick();
    push("reset", 0, 32'h1000, 0, 0, 0, 0, 0); tick();
    rst = 1'b0;
    push("boot", 0, 32'h1000, 1, 0, 0, 0, 0); tick();
    push("seq1", 0, 32'h1004, 1, 0, 0, 0, 1); tick();
    push("seq2", 0, 32'h1008, 1, 0, 0, 0, 2); tick();
    push("seq3", 0, 32'h100C, 1, 0, 0, 0, 3); tick();

    // Backpressure then stall
    pc_ready = 1'b0; redirect = 1'b1; redirect_target = 32'h20;
    push("redir20", 0, 32'h20, 1, 0, 0, 0, 3); tick();
    redirect = 1'b0;
    push("bp1", 0, 32'h20, 1, 0, 0, 0, 3); tick();
    push("bp2", 0, 32'h20, 1, 0, 0, 0, 3); tick();
    pc_ready = 1'b1; stall = 1'b1;
    push("stall1", 0, 32'h20, 0, 0, 0, 0, 3); tick();
    push("stall2", 0, 32'h20, 0, 0, 0, 0, 3); tick();
    stall = 1'b0;
    push("release", 0, 32'h24, 1, 0, 0, 0, 4); tick();

    // Redirect with fire, then trap over misaligned redirect
    redirect = 1'b1; redirect_target = 32'h40;
    push("redir40", 0, 32'h40, 1, 0, 0, 0, 5); tick();
    redirect_target = 32'h200;
    push("fire_redir", 0, 32'h200, 1, 0, 0, 0, 6); tick();
    pc_ready = 1'b0; trap = 1'b1; trap_vec = 32'h103; redirect_target = 32'h302;
    push("trap_prio", 0, 32'h100, 1, 0, 0, 0, 6); tick();
    trap = 1'b0;

    // Misaligned redirects, back to back
    push("mis1", 0, 32'h100, 1, 0, 1, 32'h302, 6); tick();
    redirect_target = 32'h305;
    push("mis2", 0, 32'h100, 1, 0, 1, 32'h305, 6); tick();
    redirect = 1'b0;
    push("mis_end", 0, 32'h100, 1, 0, 0, 32'h305, 6); tick();

    // Halt with fire, redirect while halted, resume
    redirect = 1'b1; redirect_target = 32'h80;
    push("redir80", 0, 32'h80, 1, 0, 0, 32'h305, 6); tick();
    redirect = 1'b0; halt_req = 1'b1; pc_ready = 1'b1;
    push("halt_fire", 0, 32'h84, 0, 1, 0, 32'h305, 7); tick();
    halt_req = 1'b0; redirect = 1'b1; redirect_target = 32'h400;
    push("halt_redir", 0, 32'h400, 0, 1, 0, 32'h305, 7); tick();
    redirect = 1'b0; halt_req = 1'b1; resume = 1'b1;
    push("halt_and_resume", 0, 32'h400, 0, 1, 0, 32'h305, 7); tick();
    halt_req = 1'b0;
    push("resume", 0, 32'h400, 1, 0, 0, 32'h305, 7); tick();
    resume = 1'b0;
    push("cnt_wrap", 0, 32'h404, 1, 0, 0, 32'h305, 0); tick();

    // Reset mid-run overrides a concurrent redirect
    rst = 1'b1; redirect = 1'b1; redirect_target = 32'h500;
    push("rst_mid", 0, 32'h1000, 0, 0, 0, 0, 0);
    push("b_reset", 1, 32'h0, 0, 0, 0, 0, 0); tick();
    rst = 1'b0; redirect = 1'b0; pc_ready = 1'b0;
    push("b_boot", 1, 32'h0, 1, 0, 0, 0, 0); tick();

    // C_EXT=1: 2-byte aligned target accepted, compressed step and wrap
    redirect = 1'b1; redirect_target = 32'h302;
    push("b_redir302", 1, 32'h302, 1, 0, 0, 0, 0); tick();
    redirect_target = 32'hFFFF_FFFE;
    push("b_redir_top", 1, 32'hFFFF_FFFE, 1, 0, 0, 0, 0); tick();
    redirect = 1'b0; is_compressed = 1'b1; pc_ready = 1'b1;
    push("b_wrap", 1, 32'h0, 1, 0, 0, 0, 1); tick();
    redirect = 1'b1; redirect_target = 32'h10; pc_ready = 1'b0;
    push("b_redir10", 1, 32'h10, 1, 0, 0, 0, 1); tick();
    redirect = 1'b0; pc_ready = 1'b1;
    push("b_c_step", 1, 32'h12, 1, 0, 0, 0, 2); tick();
    is_compressed = 1'b0;
    push("b_full_step", 1, 32'h16, 1, 0, 0, 0, 3); tick();
    pc_ready = 1'b0; redirect = 1'b1; redirect_target = 32'h301;
    push("b_mis_odd", 1, 32'h100, 1, 0, 1, 32'h301, 3); tick();
    redirect = 1'b0;
    push("b_mis_end", 1, 32'h100, 1, 0, 0, 32'h301, 3); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
